// File: rtl/uart_ascii_rx_if.sv
// uart_ascii_rx_if: serial input and received-byte/display outputs of the UART ASCII receiver
interface uart_ascii_rx_if;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_error;
  logic       busy;
  logic [7:0] ascii_char_1;
  logic [7:0] ascii_char_2;
  modport master (output rx, input rx_data, rx_valid, frame_error, busy, ascii_char_1, ascii_char_2);
  modport slave  (input rx, output rx_data, rx_valid, frame_error, busy, ascii_char_1, ascii_char_2);
endinterface

// File: rtl/uart_ascii_rx.sv
// uart_ascii_rx: 8N1 UART receiver driving a two-digit ASCII display pair
module uart_ascii_rx #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 9600
) (
  input logic             clk,
  input logic             clear,
  uart_ascii_rx_if.slave  bus
);
  localparam int CPB  = CLK_FREQ / BAUD;
  localparam int HALF = CPB / 2;
  localparam int CW   = $clog2(CPB);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

  state_t        r_state, w_state;
  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt, w_cnt;
  logic [2:0]    r_bit, w_bit;
  logic [7:0]    r_sh, w_sh, r_data, w_data, r_c1, w_c1, r_c2, w_c2;
  logic          r_valid, w_valid, r_ferr, w_ferr;
  logic          w_rx_s, w_digit, w_clr, w_bs;

  assign w_rx_s  = r_sync[1];
  assign w_digit = (r_sh >= 8'h30) && (r_sh <= 8'h39);
  assign w_clr   = (r_sh == 8'h63) || (r_sh == 8'h43);
  assign w_bs    = r_sh == 8'h08;

  // state and datapath registers, with the pin synchronizer idling high
  always_ff @(posedge clk) begin
    if (clear) begin
      r_state <= IDLE;
      r_sync  <= 2'b11;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_sh    <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_c1    <= 8'h30;
      r_c2    <= 8'h30;
    end else begin
      r_state <= w_state;
      r_sync  <= {r_sync[0], bus.rx};
      r_cnt   <= w_cnt;
      r_bit   <= w_bit;
      r_sh    <= w_sh;
      r_data  <= w_data;
      r_valid <= w_valid;
      r_ferr  <= w_ferr;
      r_c1    <= w_c1;
      r_c2    <= w_c2;
    end
  end

  // frame sequencing; a good stop bit commits the byte and updates the display pair
  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt + CW'(1);
    w_bit   = r_bit;
    w_sh    = r_sh;
    w_data  = r_data;
    w_valid = 1'b0;
    w_ferr  = 1'b0;
    w_c1    = r_c1;
    w_c2    = r_c2;
    case (r_state)
      IDLE: begin
        w_cnt = '0;
        if (!w_rx_s) w_state = START;
      end
      START: if (r_cnt == CW'(HALF - 1)) begin
        w_cnt   = '0;
        w_bit   = '0;
        w_state = w_rx_s ? IDLE : DATA;
      end
      DATA: if (r_cnt == CW'(CPB - 1)) begin
        w_cnt        = '0;
        w_sh[r_bit]  = w_rx_s;
        w_bit        = r_bit + 3'd1;
        if (r_bit == 3'd7) w_state = STOP;
      end
      STOP: if (r_cnt == CW'(CPB - 1)) begin
        w_cnt = '0;
        if (w_rx_s) begin
          w_state = IDLE;
          w_data  = r_sh;
          w_valid = 1'b1;
          w_c1    = w_digit ? r_c2 : (w_clr || w_bs) ? 8'h30 : r_c1;
          w_c2    = w_digit ? r_sh : w_clr ? 8'h30 : w_bs ? r_c1 : r_c2;
        end else begin
          w_state = WAIT_IDLE;
          w_ferr  = 1'b1;
        end
      end
      WAIT_IDLE: if (w_rx_s) w_state = IDLE;
      default: w_state = IDLE;
    endcase
  end

  assign bus.rx_data      = r_data;
  assign bus.rx_valid     = r_valid;
  assign bus.frame_error  = r_ferr;
  assign bus.busy         = r_state != IDLE;
  assign bus.ascii_char_1 = r_c1;
  assign bus.ascii_char_2 = r_c2;
endmodule

// File: tb/tb_uart_ascii_rx.sv
// tb_uart_ascii_rx: randomized scoreboard bench for the UART ASCII receiver
module tb_uart_ascii_rx;
  localparam int CPB = 10;

  logic clk = 1'b0;
  logic clear;
  uart_ascii_rx_if bus();

  uart_ascii_rx #(.CLK_FREQ(1_000_000), .BAUD(100_000)) dut (
    .clk   (clk),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         err;
    logic [7:0] data;
    logic [7:0] c1;
    logic [7:0] c2;
  } exp_t;

  exp_t       q[$];
  exp_t       mon_e;
  logic [7:0] disp[$];
  logic [7:0] m_last;
  int         n_vec = 0, n_err = 0, n_valid = 0, n_ferr = 0;
  time        t_valid = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  task automatic model_clear();
    disp   = '{8'h30, 8'h30};
    m_last = 8'h00;
  endtask

  task automatic idle(input int n);
    bus.rx = 1'b1;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drive_bit(input logic v);
    bus.rx = v;
    repeat (CPB) begin @(posedge clk); #1; end
  endtask

  // display is the last two typed digits: new digits push in on the right,
  // backspace drops the right one and pads '0' on the left, c/C blanks both
  task automatic send_frame(input logic [7:0] b, input bit good);
    exp_t e;
    if (good) begin
      m_last = b;
      if (b >= 8'h30 && b <= 8'h39) begin
        disp.push_back(b);
        void'(disp.pop_front());
      end else if (b == 8'h63 || b == 8'h43) begin
        disp = '{8'h30, 8'h30};
      end else if (b == 8'h08) begin
        void'(disp.pop_back());
        disp.push_front(8'h30);
      end
    end
    e = '{!good, m_last, disp[0], disp[1]};
    q.push_back(e);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(good);
  endtask

  // monitor: every output pulse is matched against the oldest expected frame
  always @(negedge clk) begin
    if (bus.rx_valid || bus.frame_error) begin
      n_valid += int'(bus.rx_valid);
      n_ferr  += int'(bus.frame_error);
      if (bus.rx_valid) t_valid = $time;
      n_vec++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_output: valid=%0b ferr=%0b data=%h chars=%h/%h, expected no output",
                 bus.rx_valid, bus.frame_error, bus.rx_data, bus.ascii_char_1, bus.ascii_char_2);
      end else begin
        mon_e = q.pop_front();
        if ({bus.rx_valid, bus.frame_error} !== {!mon_e.err, mon_e.err} || bus.rx_data !== mon_e.data ||
            bus.ascii_char_1 !== mon_e.c1 || bus.ascii_char_2 !== mon_e.c2)
        begin
          n_err++;
          $display("FAIL frame: got valid=%0b ferr=%0b data=%h chars=%h/%h, expected valid=%0b ferr=%0b data=%h chars=%h/%h",
                   bus.rx_valid, bus.frame_error, bus.rx_data, bus.ascii_char_1, bus.ascii_char_2,
                   !mon_e.err, mon_e.err, mon_e.data, mon_e.c1, mon_e.c2);
        end
      end
    end
  end

  initial begin
    #500_000;
    n_err++;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1);
  end

  initial begin
    time        t0;
    int         nv, nf, k;
    logic [7:0] b;
    bit         good;
    bus.rx = 1'b1;
    clear  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    clear = 1'b0;
    model_clear();
    chk("reset_char1", bus.ascii_char_1, 8'h30);
    chk("reset_char2", bus.ascii_char_2, 8'h30);
    chk("reset_rx_data", bus.rx_data, 8'h00);
    chk("reset_rx_valid", bus.rx_valid, 1'b0);
    chk("reset_frame_error", bus.frame_error, 1'b0);
    chk("reset_busy", bus.busy, 1'b0);
    idle(3);

    t0 = $time;
    send_frame(8'h34, 1'b1);
    chk("first_valid_latency", 32'((t_valid - t0 - 4) / 10), 98);
    send_frame(8'h32, 1'b1);
    chk("digits_rx_data", bus.rx_data, 8'h32);
    chk("digits_chars", {bus.ascii_char_1, bus.ascii_char_2}, 16'h3432);

    foreach (disp[i]) ;
    send_frame(8'h43, 1'b1); idle(2);
    chk("clear_chars", {bus.ascii_char_1, bus.ascii_char_2}, 16'h3030);
    send_frame(8'h37, 1'b1); idle(2);
    send_frame(8'h39, 1'b1); idle(2);
    send_frame(8'h08, 1'b1); idle(2);
    chk("backspace_chars", {bus.ascii_char_1, bus.ascii_char_2}, 16'h3037);
    send_frame(8'h41, 1'b1); idle(2);
    chk("other_rx_data", bus.rx_data, 8'h41);

    nv = n_valid;
    bus.rx = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    bus.rx = 1'b1;
    k = 0;
    while (!bus.busy && k < 10) begin @(posedge clk); #1; k++; end
    chk("glitch_busy_seen", bus.busy, 1'b1);
    k = 0;
    while (bus.busy && k < 20) begin @(posedge clk); #1; k++; end
    chk("glitch_busy_len_ok", (k >= 1 && k <= 6), 1'b1);
    idle(2 * CPB);
    chk("glitch_no_valid", n_valid - nv, 0);

    nf = n_ferr;
    send_frame(8'h35, 1'b0);
    bus.rx = 1'b0;
    repeat (30 * CPB) begin @(posedge clk); #1; end
    chk("break_one_frame_error", n_ferr - nf, 1);
    chk("break_busy_wait_idle", bus.busy, 1'b1);
    chk("break_chars", {bus.ascii_char_1, bus.ascii_char_2}, {disp[0], disp[1]});
    idle(2 * CPB);
    chk("break_released_idle", bus.busy, 1'b0);
    send_frame(8'h35, 1'b1); idle(2);
    chk("after_break_chars", {bus.ascii_char_1, bus.ascii_char_2}, {disp[0], disp[1]});

    nv = n_valid;
    b = 8'h39;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(b[i]);
    bus.rx = b[4];
    repeat (5) begin @(posedge clk); #1; end
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    model_clear();
    idle(12 * CPB);
    chk("midframe_no_valid", n_valid - nv, 0);
    chk("midframe_chars", {bus.ascii_char_1, bus.ascii_char_2}, 16'h3030);
    send_frame(8'h39, 1'b1); idle(2);
    chk("midframe_next_chars", {bus.ascii_char_1, bus.ascii_char_2}, 16'h3039);

    for (int n = 0; n < 40; n++) begin
      k = int'($urandom_range(0, 9));
      b = k < 5 ? 8'h30 + 8'($urandom_range(0, 9)) :
          k == 5 ? ($urandom_range(0, 1) != 0 ? 8'h63 : 8'h43) :
          k == 6 ? 8'h08 : 8'($urandom_range(0, 255));
      good = $urandom_range(0, 9) != 0;
      send_frame(b, good);
      idle(CPB * int'(good ? $urandom_range(0, 2) : $urandom_range(1, 2)));
    end
    chk("random_final_chars", {bus.ascii_char_1, bus.ascii_char_2}, {disp[0], disp[1]});
    idle(2 * CPB);
    chk("scoreboard_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
